lsu: RTL

Load/store unit. It is the consumer of the decode-stage memory encoding: load_inst (3-bit), store_mask (4-bit), store_data, plus the ALU result as the effective address. It sits between execute and write-back. It drives a single-outstanding request/response data-memory port and returns aligned, extended load data with the register write-back controls. Instructions with no memory operation pass through with one cycle of latency.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/lsu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: decode-stage memory op codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_W    = 3'b011;
  localparam logic [2:0] LD_BU   = 3'b100;
  localparam logic [2:0] LD_HU   = 3'b101;

  localparam logic [3:0] ST_NONE = 4'b0000;
  localparam logic [3:0] ST_B    = 4'b0001;
  localparam logic [3:0] ST_H    = 4'b0011;
  localparam logic [3:0] ST_W    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: op classification, misalignment, store lane
// placement and load extraction/extension for a 32-bit, 4-lane data path.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_inst,
  input  logic [3:0]  store_mask,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        is_load,
  output logic        is_store,
  output logic        misalign,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    is_load  = load_inst inside {LD_B, LD_H, LD_W, LD_BU, LD_HU};
    is_store = !is_load && (store_mask != ST_NONE);

    misalign = 1'b0;
    if (is_load) begin
      if ((load_inst == LD_H || load_inst == LD_HU) && addr_lo[0])
        misalign = 1'b1;
      if (load_inst == LD_W && addr_lo != 2'b00)
        misalign = 1'b1;
    end else if (is_store) begin
      if (store_mask == ST_H && addr_lo[0])
        misalign = 1'b1;
      if (store_mask == ST_W && addr_lo != 2'b00)
        misalign = 1'b1;
    end

    wmask = store_mask << addr_lo;

    // Replicating narrow stores puts the data in every lane the mask could select.
    case (store_mask)
      ST_B:    wdata = {4{store_data[7:0]}};
      ST_H:    wdata = {2{store_data[15:0]}};
      default: wdata = store_data << {addr_lo, 3'b000};
    endcase

    shifted = rdata >> {addr_lo, 3'b000};
    case (load_inst)
      LD_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      LD_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      LD_BU:   load_data = {24'd0, shifted[7:0]};
      LD_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and write-back: one outstanding memory access,
// aligned/extended load results, single-cycle pass-through for non-memory ops.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [2:0]                in_load_inst,
  input  logic [3:0]                in_store_mask,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic                      in_regW,
  input  logic [REG_ADDR_WIDTH-1:0] in_regAddr,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic                      mem_req_wen,
  output logic [3:0]                mem_req_wmask,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      w_regW,
  output logic [REG_ADDR_WIDTH-1:0] w_regAddr,
  output logic [DATA_WIDTH-1:0]     w_regData,
  output logic                      misalign
);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            load_q;
  logic [3:0]            mask_q;
  logic [DATA_WIDTH-1:0] sdata_q;
  logic                  regw_q;

  logic        a_is_load, a_is_store, a_misalign;
  logic [1:0]  a_addr_lo;
  logic [2:0]  a_load;
  logic [3:0]  a_mask;
  logic [31:0] a_sdata;
  logic [3:0]  a_wmask;
  logic [31:0] a_wdata, a_load_data;
  logic        accept, idle;

  // In IDLE the aligner classifies the incoming op; afterwards it works on the captured copy.
  assign idle      = (state == S_IDLE);
  assign a_addr_lo = idle ? in_addr[1:0]  : addr_q[1:0];
  assign a_load    = idle ? in_load_inst  : load_q;
  assign a_mask    = idle ? in_store_mask : mask_q;
  assign a_sdata   = idle ? in_store_data : sdata_q;

  lsu_align u_align (
    .addr_lo    (a_addr_lo),
    .load_inst  (a_load),
    .store_mask (a_mask),
    .store_data (a_sdata),
    .rdata      (mem_rsp_rdata),
    .is_load    (a_is_load),
    .is_store   (a_is_store),
    .misalign   (a_misalign),
    .wmask      (a_wmask),
    .wdata      (a_wdata),
    .load_data  (a_load_data)
  );

  assign accept        = idle && in_valid;
  assign mem_req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_req_wen   = a_is_store;
  assign mem_req_wmask = a_wmask;
  assign mem_req_wdata = a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ((!a_is_load && !a_is_store) || a_misalign) state_nxt = S_DONE;
          else                                           state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      load_q    <= '0;
      mask_q    <= '0;
      sdata_q   <= '0;
      regw_q    <= 1'b0;
      w_regW    <= 1'b0;
      w_regAddr <= '0;
      w_regData <= '0;
      misalign  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= in_addr;
        load_q    <= in_load_inst;
        mask_q    <= in_store_mask;
        sdata_q   <= in_store_data;
        regw_q    <= in_regW;
        w_regAddr <= in_regAddr;
        if (!a_is_load && !a_is_store) begin
          w_regData <= in_addr;
          w_regW    <= in_regW;
          misalign  <= 1'b0;
        end else begin
          w_regData <= '0;
          w_regW    <= 1'b0;
          misalign  <= a_misalign;
        end
      end
      if (state == S_WAIT && mem_rsp_valid) begin
        if (a_is_load) begin
          w_regData <= a_load_data;
          w_regW    <= regw_q;
        end else begin
          w_regData <= '0;
          w_regW    <= 1'b0;
        end
      end
      if (state == S_DONE && out_ready) begin
        w_regW   <= 1'b0;
        misalign <= 1'b0;
      end
    end
  end

endmodule
